// File: rtl/ram_ctrl_pkg.sv
// Shared encodings for the 1RW+1R RAM controller: FSM states and port-0 priority.
package ram_ctrl_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } prio_t;

endpackage

// File: rtl/ram_1rw1r_ctrl_rr_arb2.sv
// Two-way round-robin arbiter (write vs read) with a single priority flop.
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_wr,
  input  logic req_rd,
  output logic gnt_wr,
  output logic gnt_rd
);

  prio_t prio;
  logic  contended;

  assign contended = en & req_wr & req_rd;

  always_comb begin
    gnt_wr = en & req_wr & (~req_rd | (prio == PRIO_WR));
    gnt_rd = en & req_rd & (~req_wr | (prio == PRIO_RD));
  end

  // Priority only rotates when both requesters actually competed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= PRIO_WR;
    end else if (contended) begin
      prio <= (prio == PRIO_WR) ? PRIO_RD : PRIO_WR;
    end
  end

endmodule

// File: rtl/ram_1rw1r_ctrl.sv
// Controller sharing a 1RW+1R RAM between write/read (port 0) and lookup (port 1),
// with a clear walk after reset/flush. Optional RAM_CTRL_LK_BYPASS_EN forwards same-cycle writes to lookups.
module ram_1rw1r_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DBITS = 8,
  parameter int ABITS = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_req,
  output logic             busy,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [ABITS-1:0] wr_addr,
  input  logic [DBITS-1:0] wr_data,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [ABITS-1:0] rd_addr,
  output logic             rd_rvalid,
  output logic [DBITS-1:0] rd_rdata,
  input  logic             lk_valid,
  output logic             lk_ready,
  input  logic [ABITS-1:0] lk_addr,
  output logic             lk_rvalid,
  output logic [DBITS-1:0] lk_rdata,
  output logic [ABITS-1:0] ram_addr0,
  output logic             ram_re0,
  output logic             ram_we0,
  output logic [DBITS-1:0] ram_wr0,
  input  logic [DBITS-1:0] ram_rd0,
  output logic [ABITS-1:0] ram_addr1,
  output logic             ram_re1,
  input  logic [DBITS-1:0] ram_rd1
);

  state_t           state, state_nxt;
  logic [ABITS-1:0] clr_cnt, clr_cnt_nxt;
  logic             grant_en;
  logic             wr_gnt, rd_gnt;
  logic             lk_hs;

  // Nothing is granted in the cycle a flush is sampled.
  assign grant_en = (state == ST_RUN) & ~flush_req;
  assign lk_hs    = lk_valid & grant_en;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (grant_en),
    .req_wr (wr_valid),
    .req_rd (rd_valid),
    .gnt_wr (wr_gnt),
    .gnt_rd (rd_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      ST_CLEAR: begin
        clr_cnt_nxt = clr_cnt + ABITS'(1);
        if (clr_cnt == '1) begin
          state_nxt   = ST_RUN;
          clr_cnt_nxt = '0;
        end
      end
      ST_RUN: begin
        if (flush_req) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = ST_CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    busy      = (state == ST_CLEAR);
    wr_ready  = wr_gnt;
    rd_ready  = rd_gnt;
    lk_ready  = grant_en;
    ram_addr0 = '0;
    ram_re0   = 1'b0;
    ram_we0   = 1'b0;
    ram_wr0   = '0;
    ram_addr1 = lk_addr;
    ram_re1   = lk_hs;
    if (state == ST_CLEAR) begin
      ram_we0   = 1'b1;
      ram_addr0 = clr_cnt;
    end else if (wr_gnt) begin
      ram_we0   = 1'b1;
      ram_addr0 = wr_addr;
      ram_wr0   = wr_data;
    end else if (rd_gnt) begin
      ram_re0   = 1'b1;
      ram_addr0 = rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_rvalid <= 1'b0;
      lk_rvalid <= 1'b0;
    end else begin
      rd_rvalid <= rd_gnt;
      lk_rvalid <= lk_hs;
    end
  end

  assign rd_rdata = ram_rd0;

`ifdef RAM_CTRL_LK_BYPASS_EN
  logic             byp_hit;
  logic [DBITS-1:0] byp_data;

  // The RAM returns old contents on a same-cycle collision; remember the write instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit <= lk_hs & wr_gnt & (lk_addr == wr_addr);
      if (lk_hs & wr_gnt) begin
        byp_data <= wr_data;
      end
    end
  end

  assign lk_rdata = byp_hit ? byp_data : ram_rd1;
`else
  assign lk_rdata = ram_rd1;
`endif

endmodule

// File: tb/tb_ram_1rw1r_ctrl.sv
// Scoreboard bench for ram_1rw1r_ctrl with a behavioural RAM and reference memory model.
module tb_ram_1rw1r_ctrl;

  localparam int DBITS = 8;
  localparam int ABITS = 4;
  localparam int DEPTH = 1 << ABITS;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush_req;
  logic             busy;
  logic             wr_valid, wr_ready;
  logic [ABITS-1:0] wr_addr;
  logic [DBITS-1:0] wr_data;
  logic             rd_valid, rd_ready;
  logic [ABITS-1:0] rd_addr;
  logic             rd_rvalid;
  logic [DBITS-1:0] rd_rdata;
  logic             lk_valid, lk_ready;
  logic [ABITS-1:0] lk_addr;
  logic             lk_rvalid;
  logic [DBITS-1:0] lk_rdata;
  logic [ABITS-1:0] ram_addr0, ram_addr1;
  logic             ram_re0, ram_we0, ram_re1;
  logic [DBITS-1:0] ram_wr0, ram_rd0, ram_rd1;

  ram_1rw1r_ctrl #(.DBITS(DBITS), .ABITS(ABITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_req (flush_req),
    .busy      (busy),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rd_rvalid (rd_rvalid),
    .rd_rdata  (rd_rdata),
    .lk_valid  (lk_valid),
    .lk_ready  (lk_ready),
    .lk_addr   (lk_addr),
    .lk_rvalid (lk_rvalid),
    .lk_rdata  (lk_rdata),
    .ram_addr0 (ram_addr0),
    .ram_re0   (ram_re0),
    .ram_we0   (ram_we0),
    .ram_wr0   (ram_wr0),
    .ram_rd0   (ram_rd0),
    .ram_addr1 (ram_addr1),
    .ram_re1   (ram_re1),
    .ram_rd1   (ram_rd1)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: synchronous read, read-before-write across ports.
  logic [DBITS-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we0) mem[ram_addr0] <= ram_wr0;
    if (ram_re0) ram_rd0 <= mem[ram_addr0];
    if (ram_re1) ram_rd1 <= mem[ram_addr1];
  end

  typedef struct {
    logic [DBITS-1:0] data;
    int unsigned      cyc;
  } resp_t;

  resp_t            rd_q[$];
  resp_t            lk_q[$];
  int unsigned      cyc = 0;
  int unsigned      n_chk = 0;
  int unsigned      n_pass = 0;
  int               m_busy_left = DEPTH;
  bit               m_prio_rd = 1'b0;
  logic [DBITS-1:0] ref_mem [DEPTH];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: a clear countdown, an alternating tie-breaker and a plain array.
  always @(negedge clk) begin
    bit               ew, er;
    logic [DBITS-1:0] lexp;
    if (!rst_n) begin
      m_busy_left = DEPTH;
      m_prio_rd   = 1'b0;
      check("rst_busy", busy, 1);
      check("rst_rd_rvalid", rd_rvalid, 0);
      check("rst_lk_rvalid", lk_rvalid, 0);
      check("rst_ready", {wr_ready, rd_ready, lk_ready}, 0);
    end else if (m_busy_left > 0) begin
      check("clr_busy", busy, 1);
      check("clr_ready", {wr_ready, rd_ready, lk_ready}, 0);
      check("clr_port0", {ram_we0, ram_re0, ram_addr0, ram_wr0},
            {1'b1, 1'b0, 4'(DEPTH - m_busy_left), 8'h00});
      check("clr_re1", ram_re1, 0);
      ref_mem[DEPTH - m_busy_left] = '0;
      m_busy_left--;
    end else begin
      check("run_busy", busy, 0);
      if (flush_req) begin
        check("flush_ready", {wr_ready, rd_ready, lk_ready}, 0);
        m_busy_left = DEPTH;
      end else begin
        ew = wr_valid;
        er = rd_valid;
        if (wr_valid && rd_valid) begin
          ew        = !m_prio_rd;
          er        = m_prio_rd;
          m_prio_rd = !m_prio_rd;
        end
        check("wr_ready", wr_ready, ew);
        check("rd_ready", rd_ready, er);
        check("lk_ready", lk_ready, 1);
        check("ram_re1", ram_re1, lk_valid);
        check("re_we_excl", ram_we0 & ram_re0, 0);
        if (er) begin
          check("rd_port", {ram_re0, ram_addr0}, {1'b1, rd_addr});
          rd_q.push_back('{data: ref_mem[rd_addr], cyc: cyc + 1});
        end
        if (lk_valid) begin
          lexp = ref_mem[lk_addr];
`ifdef RAM_CTRL_LK_BYPASS_EN
          if (ew && wr_addr == lk_addr) lexp = wr_data;
`endif
          lk_q.push_back('{data: lexp, cyc: cyc + 1});
        end
        if (ew) begin
          check("wr_port", {ram_we0, ram_addr0, ram_wr0}, {1'b1, wr_addr, wr_data});
          ref_mem[wr_addr] = wr_data;
        end
      end
    end
  end

  // Monitor: pops expected responses whenever the DUT strobes rvalid.
  always @(negedge clk) begin
    resp_t r;
    if (rst_n) begin
      if (rd_rvalid) begin
        if (rd_q.size() == 0) check("rd_unexpected_rvalid", rd_rvalid, 0);
        else begin
          r = rd_q.pop_front();
          check("rd_rdata", rd_rdata, r.data);
          check("rd_latency", cyc, r.cyc);
        end
      end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        check("rd_missing_rvalid", rd_rvalid, 1);
        void'(rd_q.pop_front());
      end
      if (lk_rvalid) begin
        if (lk_q.size() == 0) check("lk_unexpected_rvalid", lk_rvalid, 0);
        else begin
          r = lk_q.pop_front();
          check("lk_rdata", lk_rdata, r.data);
          check("lk_latency", cyc, r.cyc);
        end
      end else if (lk_q.size() > 0 && lk_q[0].cyc <= cyc) begin
        check("lk_missing_rvalid", lk_rvalid, 1);
        void'(lk_q.pop_front());
      end
    end
  end

  task automatic drive(input logic wv, input logic [ABITS-1:0] wa, input logic [DBITS-1:0] wd,
                       input logic rv, input logic [ABITS-1:0] ra,
                       input logic lv, input logic [ABITS-1:0] la, input logic fl);
    wr_valid  = wv;
    wr_addr   = wa;
    wr_data   = wd;
    rd_valid  = rv;
    rd_addr   = ra;
    lk_valid  = lv;
    lk_addr   = la;
    flush_req = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, '0, 0, '0, 0, '0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rd_q.delete();
    lk_q.delete();
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DBITS'($urandom);
    rst_n = 1'b0;
    idle(1);
    do_reset();
    idle(DEPTH + 1);

    for (int a = 0; a < DEPTH; a++) drive(0, '0, '0, 1, ABITS'(a), 0, '0, 0);
    idle(1);

    drive(1, 4'd3, 8'hA5, 0, '0, 0, '0, 0);
    drive(0, '0, '0, 1, 4'd3, 0, '0, 0);
    idle(1);

    for (int i = 0; i < 4; i++) drive(1, ABITS'(i + 8), DBITS'(8'h50 + i), 1, 4'd9, 0, '0, 0);
    idle(1);

    drive(1, 4'd5, 8'h11, 0, '0, 0, '0, 0);
    drive(1, 4'd5, 8'h3C, 0, '0, 1, 4'd5, 0);
    drive(0, '0, '0, 0, '0, 1, 4'd5, 0);
    idle(1);

    drive(1, 4'd7, 8'hFF, 0, '0, 0, '0, 0);
    drive(1, 4'd2, 8'h77, 1, 4'd7, 1, 4'd7, 1);
    idle(DEPTH + 1);
    drive(0, '0, '0, 1, 4'd7, 1, 4'd3, 0);
    idle(1);

    drive(0, '0, '0, 0, '0, 0, '0, 1);
    idle(9);
    do_reset();
    idle(DEPTH + 1);

    for (int i = 0; i < 600; i++) begin
      logic [ABITS-1:0] wa, ra, la;
      wa = ($urandom_range(0, 1) == 0) ? ABITS'($urandom_range(0, 3)) : ABITS'($urandom);
      ra = ($urandom_range(0, 1) == 0) ? ABITS'($urandom_range(0, 3)) : ABITS'($urandom);
      la = ($urandom_range(0, 1) == 0) ? ABITS'($urandom_range(0, 3)) : ABITS'($urandom);
      drive(1'($urandom), wa, DBITS'($urandom), 1'($urandom), ra,
            1'($urandom), la, ($urandom_range(0, 99) == 0));
    end
    idle(DEPTH + 3);

    check("rd_q_drained", rd_q.size(), 0);
    check("lk_q_drained", lk_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_1rw1r_ctrl.md
# ram_1rw1r_ctrl

Controller that owns a 1RW+1R generic RAM instance and shares its ports between three requesters. Port 0 is arbitrated round-robin between a write requester and a read requester. Port 1 serves a lookup requester. The block also clears the whole array to zero after reset and on flush, since the RAM itself has no reset. It sits between the cache/predictor logic and the RAM macro.

## Interface
Parameters:
- DBITS, 8, RAM data width
- ABITS, 12, RAM address width; DEPTH = 2^ABITS

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- flush_req  in  1  pulse: start a clear walk (accepted in RUN only)
- busy  out  1  high while clearing
- wr_valid / wr_ready  in / out  1  write request handshake
- wr_addr  in  ABITS  write address
- wr_data  in  DBITS  write data
- rd_valid / rd_ready  in / out  1  port-0 read request handshake
- rd_addr  in  ABITS  read address
- rd_rvalid  out  1  read response strobe
- rd_rdata  out  DBITS  read response data
- lk_valid / lk_ready  in / out  1  port-1 lookup handshake
- lk_addr  in  ABITS  lookup address
- lk_rvalid  out  1  lookup response strobe
- lk_rdata  out  DBITS  lookup response data
- ram_addr0  out  ABITS  RAM port-0 address
- ram_re0  out  1  RAM port-0 read enable
- ram_we0  out  1  RAM port-0 write enable
- ram_wr0  out  DBITS  RAM port-0 write data
- ram_rd0  in  DBITS  RAM port-0 read data
- ram_addr1  out  ABITS  RAM port-1 address
- ram_re1  out  1  RAM port-1 read enable
- ram_rd1  in  DBITS  RAM port-1 read data

The RAM's own synchronous reset input is tied inactive outside this block.

## Operation
FSM states: CLEAR, RUN.
- Reset enters CLEAR with clr_cnt = 0.
- CLEAR: each cycle drives ram_we0 = 1, ram_addr0 = clr_cnt, ram_wr0 = 0, then increments clr_cnt.
- CLEAR exits to RUN after the cycle that writes DEPTH-1, so the walk takes exactly DEPTH cycles.
- In CLEAR, wr_ready, rd_ready and lk_ready are all 0. flush_req is ignored.
- RUN: flush_req = 1 moves to CLEAR next cycle with clr_cnt = 0. No request is granted in the cycle flush_req is sampled.
- busy = (state == CLEAR).

Port-0 arbitration in RUN:
- At most one grant per cycle. ram_re0 and ram_we0 are never asserted together.
- Only one of wr_valid / rd_valid set: that requester is granted.
- Both set: the requester named by the priority bit `prio` wins. `prio` then flips to the other requester. `prio` resets to WR.
- Uncontended grants leave `prio` unchanged.
- Ready signals are combinational: wr_ready = RUN & wr_valid-wins; rd_ready = RUN & rd_valid-wins.
- A write grant drives ram_we0, ram_addr0 = wr_addr, ram_wr0 = wr_data.
- A read grant drives ram_re0 and ram_addr0 = rd_addr.
- rd_rvalid is registered: high for exactly one cycle, the cycle after the read grant.
- rd_rdata = ram_rd0, combinational pass-through. The RAM holds it until the next read.

Port 1:
- lk_ready = RUN. A handshake drives ram_re1 = 1 and ram_addr1 = lk_addr.
- lk_rvalid is high for exactly the following cycle.
- lk_rdata = ram_rd1, or forwarded data (see Configuration).

A port-0 read or write and a port-1 lookup may complete in the same cycle.

## Timing
- Reset values: busy = 1, rd_rvalid = 0, lk_rvalid = 0, prio = WR, clr_cnt = 0. All ready outputs are 0 while in CLEAR.
- Read latency: 1 cycle from handshake to rvalid, on both ports. There is no response backpressure.
- Write to read of the same address on port 0: the read granted in a later cycle returns the new data.
- Reset mid-CLEAR restarts the walk at address 0. Reset during RUN drops any in-flight rvalid.

## Configuration
- RAM_CTRL_LK_BYPASS_EN defined: if a lookup handshake and a port-0 write to the same address occur in cycle N, lk_rdata in cycle N+1 returns that write data. Implement this with a registered address compare plus a registered data copy.
- Macro undefined: lk_rdata = ram_rd1 always, so a same-cycle collision returns the old contents.

## Structure
- Shared package `ram_ctrl_pkg` holds the FSM state encoding (CLEAR = 0, RUN = 1) and the prio encoding (WR = 0, RD = 1).
- Sub-module `rr_arb2`: 2-way round-robin arbiter with the prio flop. The controller instantiates it for port 0.
- The controller instantiates `ram_generic_1rw1r` only in the bench wrapper, not internally.

## Test plan
- Reset with ABITS=4 -> busy = 1 for 16 cycles, addresses 0..15 written with 0; after busy falls, reading each address returns 0.
- Write addr 3 = 0xA5, then read addr 3 -> rd_rvalid one cycle after grant, rd_rdata = 0xA5.
- wr_valid and rd_valid held high for 4 cycles -> grants alternate WR, RD, WR, RD; ram_re0 and ram_we0 never both 1.
- Lookup addr 5 in the same cycle as a write of 0x3C to addr 5 -> with the macro, lk_rdata = 0x3C; without it, lk_rdata = the prior value.
- Write 0xFF to addr 7, pulse flush_req -> busy = 1 for DEPTH cycles, all ready outputs 0; afterwards a read of addr 7 returns 0.
- Assert rst_n low mid-CLEAR at clr_cnt = 9 -> walk restarts at 0, busy stays 1 for a full DEPTH cycles.
